systolic_mac_pe: RTL and testbench

Parametrised fixed-point systolic processing element. It is the next-generation PE for the matrix array: configurable Q-format, a two-stage pipelined MAC, and valid propagation. It supports both weight-stationary and output-stationary dataflow, with a saturating wide accumulator and a sticky overflow flag. It tiles in a 2-D array: a_* flows east, b_* flows south, and acc_out is read by the array drain logic.

---
 rtl/systolic_mac_pe.sv | 137 +++++++++++++
 tb/tb_systolic_mac_pe.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_mac_pe.sv
// systolic_mac_pe: fixed-point systolic PE with a two-stage pipelined MAC.
// Stage 1 multiplies and scales to the accumulator format; stage 2
// accumulates with saturation and a sticky overflow flag.
// Optional macro ROUND_NEAREST_EN selects round-half-up scaling instead of
// truncation toward -inf.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   enable            global advance; low freezes all state
//   mode              0 = a_in x weight_reg, 1 = a_in x b_in
//   load_weight       capture b_in into weight_reg
//   clear_acc         zero accumulator/ovf_flag, drop in-flight product
//   valid_in          a_in/b_in carry a MAC operand
//   a_in, b_in        west / north operands
//   a_out, b_out      registered operands to east / south neighbours
//   valid_out         registered valid_in
//   acc_out           accumulator saturated to DATA_BITS
//   ovf_flag          sticky accumulator clamp indicator
//   busy              product stage holds a pending product
module systolic_mac_pe #(
    parameter int DATA_BITS = 16,
    parameter int FRAC_BITS = 15,
    parameter int ACC_BITS  = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 mode,
    input  logic                 load_weight,
    input  logic                 clear_acc,
    input  logic                 valid_in,
    input  logic [DATA_BITS-1:0] a_in,
    input  logic [DATA_BITS-1:0] b_in,
    output logic [DATA_BITS-1:0] a_out,
    output logic [DATA_BITS-1:0] b_out,
    output logic                 valid_out,
    output logic [DATA_BITS-1:0] acc_out,
    output logic                 ovf_flag,
    output logic                 busy
);

    localparam int PW = 2 * DATA_BITS;
    // Working width for scaling: wide enough for the product plus the
    // rounding term and for sign-extension up to ACC_BITS.
    localparam int WW = ((ACC_BITS > PW) ? ACC_BITS : PW) + 2;

    localparam logic [ACC_BITS-1:0] ACC_MAX = {1'b0, {(ACC_BITS-1){1'b1}}};
    localparam logic [ACC_BITS-1:0] ACC_MIN = {1'b1, {(ACC_BITS-1){1'b0}}};
    localparam logic [DATA_BITS-1:0] OUT_MAX = {1'b0, {(DATA_BITS-1){1'b1}}};
    localparam logic [DATA_BITS-1:0] OUT_MIN = {1'b1, {(DATA_BITS-1){1'b0}}};

`ifdef ROUND_NEAREST_EN
    localparam logic signed [WW-1:0] ONE = {{(WW-1){1'b0}}, 1'b1};
    localparam int RSH = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;
    localparam logic signed [WW-1:0] RND =
        (FRAC_BITS > 0) ? (ONE << RSH) : '0;
`endif

    logic        [DATA_BITS-1:0] weight_reg;
    logic signed [DATA_BITS-1:0] op_b;
    logic signed [PW-1:0]        prod_full;
    logic signed [WW-1:0]        prod_wide;
    logic        [ACC_BITS-1:0]  scaled;
    logic        [ACC_BITS-1:0]  prod_reg;
    logic        [ACC_BITS-1:0]  acc;
    logic        [ACC_BITS:0]    sum;
    logic        [ACC_BITS-1:0]  acc_sat;
    logic                        sat_hit;
    logic [ACC_BITS-DATA_BITS:0] acc_hi;

    // Stage 1: multiply and scale to accumulator format
    assign op_b      = mode ? b_in : weight_reg;
    assign prod_full = $signed(a_in) * op_b;
    assign prod_wide = {{(WW-PW){prod_full[PW-1]}}, prod_full};

`ifdef ROUND_NEAREST_EN
    assign scaled = ACC_BITS'((prod_wide + RND) >>> FRAC_BITS);
`else
    assign scaled = ACC_BITS'(prod_wide >>> FRAC_BITS);
`endif

    // Stage 2: one extra bit exposes signed overflow of the add
    assign sum = {acc[ACC_BITS-1], acc} + {prod_reg[ACC_BITS-1], prod_reg};

    always_comb begin
        acc_sat = sum[ACC_BITS-1:0];
        sat_hit = 1'b0;
        if (sum[ACC_BITS] != sum[ACC_BITS-1]) begin
            sat_hit = 1'b1;
            acc_sat = sum[ACC_BITS] ? ACC_MIN : ACC_MAX;
        end
    end

    // Output fits when all bits above the DATA_BITS sign bit agree
    assign acc_hi = acc[ACC_BITS-1:DATA_BITS-1];

    always_comb begin
        if ((&acc_hi) || !(|acc_hi)) begin
            acc_out = acc[DATA_BITS-1:0];
        end else begin
            acc_out = acc[ACC_BITS-1] ? OUT_MIN : OUT_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_out      <= '0;
            b_out      <= '0;
            valid_out  <= 1'b0;
            weight_reg <= '0;
            prod_reg   <= '0;
            busy       <= 1'b0;
            acc        <= '0;
            ovf_flag   <= 1'b0;
        end else if (enable) begin
            a_out     <= a_in;
            b_out     <= b_in;
            valid_out <= valid_in;
            if (load_weight) begin
                weight_reg <= b_in;
            end
            // Capture happens even during clear so clear + first operand
            // needs no bubble.
            prod_reg <= scaled;
            busy     <= valid_in;
            if (clear_acc) begin
                acc      <= '0;
                ovf_flag <= 1'b0;
            end else if (busy) begin
                acc <= acc_sat;
                if (sat_hit) begin
                    ovf_flag <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_mac_pe.sv
// tb_systolic_mac_pe: randomized and directed checks of systolic_mac_pe
// against a plain-arithmetic model (24-bit and 18-bit accumulators).
module tb_systolic_mac_pe;

    localparam int F = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        mode;
    logic        load_weight;
    logic        clear_acc;
    logic        valid_in;
    logic [15:0] a_in;
    logic [15:0] b_in;

    logic [15:0] a_out, b_out, acc_out;
    logic        valid_out, ovf_flag, busy;
    logic [15:0] a_out18, b_out18, acc_out18;
    logic        valid_out18, ovf_flag18, busy18;

    int checks = 0;
    int errors = 0;

    // Model state
    longint      m_acc, m_acc18, m_prod;
    logic        m_ovf, m_ovf18, m_busy, m_v;
    logic [15:0] m_w, m_a, m_b;

    always #5 clk = ~clk;

    systolic_mac_pe dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode),
        .load_weight(load_weight), .clear_acc(clear_acc),
        .valid_in(valid_in), .a_in(a_in), .b_in(b_in),
        .a_out(a_out), .b_out(b_out), .valid_out(valid_out),
        .acc_out(acc_out), .ovf_flag(ovf_flag), .busy(busy)
    );

    systolic_mac_pe #(.ACC_BITS(18)) dut18 (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode),
        .load_weight(load_weight), .clear_acc(clear_acc),
        .valid_in(valid_in), .a_in(a_in), .b_in(b_in),
        .a_out(a_out18), .b_out(b_out18), .valid_out(valid_out18),
        .acc_out(acc_out18), .ovf_flag(ovf_flag18), .busy(busy18)
    );

    function automatic longint sx(input logic [15:0] x);
        return longint'($signed(x));
    endfunction

    // Real-valued product scaled to Q.15 LSBs
    function automatic longint scale(input longint p);
        longint q;
        q = p;
`ifdef ROUND_NEAREST_EN
        q = q + (longint'(1) <<< (F - 1));
`endif
        return q >>> F;
    endfunction

    function automatic longint clamp(input longint v, input int bits);
        longint hi, lo;
        hi = (longint'(1) <<< (bits - 1)) - 1;
        lo = -(longint'(1) <<< (bits - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic logic [15:0] exp_out(input longint v);
        return 16'(clamp(v, 16));
    endfunction

    task automatic model_step();
        longint s, t;
        if (reset) begin
            m_acc = 0; m_acc18 = 0; m_prod = 0;
            m_ovf = 0; m_ovf18 = 0; m_busy = 0; m_v = 0;
            m_w = 0; m_a = 0; m_b = 0;
        end else if (enable) begin
            s = scale(sx(a_in) * sx(mode ? b_in : m_w));
            if (clear_acc) begin
                m_acc = 0; m_acc18 = 0; m_ovf = 0; m_ovf18 = 0;
            end else if (m_busy) begin
                t = m_acc + m_prod;
                if (clamp(t, 24) != t) m_ovf = 1;
                m_acc = clamp(t, 24);
                t = m_acc18 + m_prod;
                if (clamp(t, 18) != t) m_ovf18 = 1;
                m_acc18 = clamp(t, 18);
            end
            m_prod = s;
            m_busy = valid_in;
            if (load_weight) m_w = b_in;
            m_a = a_in; m_b = b_in; m_v = valid_in;
        end
    endtask

    task automatic cyc(input logic en, input logic md, input logic lw,
                       input logic clr, input logic vi,
                       input logic [15:0] a, input logic [15:0] b);
        enable = en; mode = md; load_weight = lw;
        clear_acc = clr; valid_in = vi; a_in = a; b_in = b;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(1, 0, 0, 0, 0, 16'h1234, 16'h5678);
        cyc(0, 1, 1, 1, 1, 16'h1111, 16'h2222);
        checks++;
        if ({a_out, b_out, acc_out, valid_out, ovf_flag, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outs got a=%h b=%h acc=%h v=%b o=%b bz=%b want 0",
                     a_out, b_out, acc_out, valid_out, ovf_flag, busy);
        end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 0, 0, 0, 16'h0, 16'h0);
            checks++;
            if (acc_out !== 16'h0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle got acc=%h busy=%b want 0000/0",
                         acc_out, busy);
            end
        end
    endtask

    task automatic test_weight_stationary();
        logic [15:0] want [3];
        want = '{16'h2000, 16'h4000, 16'h6000};
        cyc(1, 0, 1, 1, 0, 16'h0, 16'h4000);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 0, 1, 16'h4000, 16'(i));
            checks++;
            if (a_out !== 16'h4000 || b_out !== 16'(i)) begin
                errors++;
                $display("FAIL ws_echo got a=%h b=%h want 4000 %h",
                         a_out, b_out, 16'(i));
            end
        end
        for (int i = 1; i < 3; i++) begin
            if (i == 2) cyc(1, 0, 0, 0, 0, 16'h0, 16'h0);
            checks++;
            if (acc_out !== exp_out(m_acc)) begin
                errors++;
                $display("FAIL ws_model got %h want %h", acc_out, exp_out(m_acc));
            end
        end
        cyc(1, 0, 0, 0, 0, 16'h0, 16'h0);
        checks++;
        if (acc_out !== want[2]) begin
            errors++;
            $display("FAIL ws_final got %h want %h", acc_out, want[2]);
        end
    endtask

    task automatic test_output_stationary();
        cyc(1, 1, 0, 1, 0, 16'h0, 16'h0);
        cyc(1, 1, 0, 0, 1, 16'hC000, 16'h4000);
        cyc(1, 1, 0, 0, 0, 16'h0, 16'h0);
        checks++;
        if (acc_out !== 16'hE000) begin
            errors++;
            $display("FAIL os_neg got %h want e000", acc_out);
        end
        cyc(1, 1, 0, 0, 1, 16'h8000, 16'h8000);
        cyc(1, 1, 0, 0, 0, 16'h0, 16'h0);
        checks++;
        if (acc_out !== 16'h6000 || m_acc != 64'sh6000) begin
            errors++;
            $display("FAIL os_m1xm1 got %h want 6000", acc_out);
        end
    endtask

    task automatic test_saturation();
        cyc(1, 1, 0, 1, 0, 16'h0, 16'h0);
        for (int i = 0; i < 7; i++) cyc(1, 1, 0, 0, 1, 16'h7FFF, 16'h7FFF);
        cyc(1, 1, 0, 0, 0, 16'h0, 16'h0);
        checks++;
        if (ovf_flag18 !== 1'b1 || acc_out18 !== 16'h7FFF) begin
            errors++;
            $display("FAIL sat_pos18 got ovf=%b acc=%h want 1 7fff",
                     ovf_flag18, acc_out18);
        end
        checks++;
        if (ovf_flag !== 1'b0 || acc_out !== 16'h7FFF) begin
            errors++;
            $display("FAIL sat_out24 got ovf=%b acc=%h want 0 7fff",
                     ovf_flag, acc_out);
        end
        cyc(1, 1, 0, 1, 0, 16'h0, 16'h0);
        checks++;
        if (acc_out18 !== 16'h0 || ovf_flag18 !== 1'b0) begin
            errors++;
            $display("FAIL sat_clear got acc=%h ovf=%b want 0000 0",
                     acc_out18, ovf_flag18);
        end
        for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, 1, 16'h8000, 16'h7FFF);
        cyc(1, 1, 0, 0, 0, 16'h0, 16'h0);
        checks++;
        if (ovf_flag18 !== 1'b1 || acc_out18 !== 16'h8000) begin
            errors++;
            $display("FAIL sat_neg18 got ovf=%b acc=%h want 1 8000",
                     ovf_flag18, acc_out18);
        end
    endtask

    task automatic test_clear_enable();
        cyc(1, 1, 0, 0, 1, 16'h2000, 16'h7000);
        cyc(1, 1, 0, 1, 1, 16'h4000, 16'h4000);
        cyc(1, 1, 0, 0, 0, 16'h0, 16'h0);
        checks++;
        if (acc_out !== 16'h2000 || ovf_flag !== 1'b0) begin
            errors++;
            $display("FAIL clr_seamless got %h ovf=%b want 2000 0",
                     acc_out, ovf_flag);
        end
        cyc(1, 1, 0, 0, 1, 16'h1000, 16'h4000);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 1, 1, 1, 16'($urandom), 16'($urandom));
            checks++;
            if (acc_out !== 16'h2000 || busy !== 1'b1 || a_out !== 16'h1000) begin
                errors++;
                $display("FAIL en_freeze got acc=%h busy=%b a=%h want 2000 1 1000",
                         acc_out, busy, a_out);
            end
        end
        cyc(1, 1, 0, 0, 0, 16'h0, 16'h0);
        checks++;
        if (acc_out !== 16'h2800) begin
            errors++;
            $display("FAIL en_resume got %h want 2800", acc_out);
        end
    endtask

    task automatic test_rounding();
        logic [15:0] w1, w2;
`ifdef ROUND_NEAREST_EN
        w1 = 16'h0001; w2 = 16'h0000;
`else
        w1 = 16'h0000; w2 = 16'hFFFF;
`endif
        cyc(1, 1, 0, 1, 1, 16'h0001, 16'h4000);
        cyc(1, 1, 0, 0, 0, 16'h0, 16'h0);
        checks++;
        if (acc_out !== w1) begin
            errors++;
            $display("FAIL round_pos got %h want %h", acc_out, w1);
        end
        cyc(1, 1, 0, 1, 1, 16'hFFFF, 16'h4000);
        cyc(1, 1, 0, 0, 0, 16'h0, 16'h0);
        checks++;
        if (acc_out !== w2) begin
            errors++;
            $display("FAIL round_neg got %h want %h", acc_out, w2);
        end
    endtask

    task automatic test_random();
        logic [15:0] a, b;
        for (int i = 0; i < 300; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if ($urandom_range(0, 3) == 0) a = 16'(a >>> 4);
            cyc($urandom_range(0, 7) != 0, 1'($urandom),
                $urandom_range(0, 5) == 0, $urandom_range(0, 15) == 0,
                1'($urandom), a, b);
            checks++;
            if (acc_out !== exp_out(m_acc) || ovf_flag !== m_ovf ||
                busy !== m_busy) begin
                errors++;
                $display("FAIL rnd24 i=%0d got acc=%h o=%b bz=%b want %h %b %b",
                         i, acc_out, ovf_flag, busy, exp_out(m_acc), m_ovf, m_busy);
            end
            checks++;
            if (acc_out18 !== exp_out(m_acc18) || ovf_flag18 !== m_ovf18) begin
                errors++;
                $display("FAIL rnd18 i=%0d got acc=%h o=%b want %h %b",
                         i, acc_out18, ovf_flag18, exp_out(m_acc18), m_ovf18);
            end
            checks++;
            if (a_out !== m_a || b_out !== m_b || valid_out !== m_v) begin
                errors++;
                $display("FAIL rnd_fwd i=%0d got %h %h %b want %h %h %b",
                         i, a_out, b_out, valid_out, m_a, m_b, m_v);
            end
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; mode = 1'b0; load_weight = 1'b0;
        clear_acc = 1'b0; valid_in = 1'b0; a_in = '0; b_in = '0;
        @(negedge clk);
        test_reset();
        test_weight_stationary();
        test_output_stationary();
        test_saturation();
        test_clear_enable();
        test_rounding();
        test_random();
        reset = 1'b1;
        cyc(1, 0, 0, 0, 0, 16'h0, 16'h0);
        checks++;
        if (acc_out !== 16'h0 || busy !== 1'b0 || ovf_flag18 !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got acc=%h busy=%b ovf18=%b want 0",
                     acc_out, busy, ovf_flag18);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
